// File: rtl/ctrl_mem_stall_if.sv
// Signal bundle between decode/EX control and the data-memory stall controller.
// dmem handshake: o_dmem_req stays high until a final-access or wait cycle sees i_dmem_ready (or the wait times out).
interface ctrl_mem_stall_if;
  logic [15:0] i_ir_ex;
  logic [3:0]  i_mem_data_access;
  logic        i_dmem_ready;
  logic        o_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic        o_rf_we_r;
  logic [2:0]  o_wb_rd_r;
  logic        o_err_r;
  logic [1:0]  state_dbg;

  modport master (
    output i_ir_ex, i_mem_data_access, i_dmem_ready,
    input  o_stall, o_dmem_req, o_dmem_we, o_rf_we_r, o_wb_rd_r, o_err_r, state_dbg
  );

  modport slave (
    input  i_ir_ex, i_mem_data_access, i_dmem_ready,
    output o_stall, o_dmem_req, o_dmem_we, o_rf_we_r, o_wb_rd_r, o_err_r, state_dbg
  );
endinterface

// File: rtl/ctrl_mem_stall.sv
// Data-memory stall controller: freezes IF/ID while a multi-cycle LDR/STR runs,
// waits for memory ready with a timeout, and strobes the LDR register-file write.
module ctrl_mem_stall #(
  parameter int TIMEOUT = 15
) (
  input logic            clk,
  input logic            rst,
  ctrl_mem_stall_if.slave bus
);
  localparam logic [4:0] OP_STR = 5'b01100;
  localparam logic [4:0] OP_LDR = 5'b01101;
  localparam logic [3:0] TLIM   = 4'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAITRDY, DONE} state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [3:0] tcnt, tcnt_nx;
  logic [4:0] op;
  logic [2:0] rd;
  logic       load;
  logic       rf_we_nx;
  logic       err_set;
  logic       rf_we_q;
  logic [2:0] wb_rd_q;
  logic       err_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tcnt_nx  = tcnt;
    load     = 1'b0;
    rf_we_nx = 1'b0;
    err_set  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_mem_data_access != 4'd0) begin
          state_nx = ACCESS;
          cnt_nx   = bus.i_mem_data_access - 4'd1;
          load     = 1'b1;
        end
      end
      ACCESS: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd0) begin
          if (bus.i_dmem_ready) begin
            state_nx = DONE;
            rf_we_nx = (op == OP_LDR);
          end else begin
            state_nx = WAITRDY;
            tcnt_nx  = 4'd0;
          end
        end
      end
      WAITRDY: begin
        if (bus.i_dmem_ready) begin
          state_nx = DONE;
          rf_we_nx = (op == OP_LDR);
        end else if (tcnt == TLIM) begin
          // Timeout: abort the access without a register-file write.
          state_nx = DONE;
          err_set  = 1'b1;
        end else begin
          tcnt_nx = tcnt + 4'd1;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      tcnt    <= 4'd0;
      op      <= 5'd0;
      rd      <= 3'd0;
      rf_we_q <= 1'b0;
      wb_rd_q <= 3'd0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      tcnt    <= tcnt_nx;
      rf_we_q <= rf_we_nx;
      if (load) begin
        op <= bus.i_ir_ex[15:11];
        rd <= bus.i_ir_ex[2:0];
      end
      if (rf_we_nx) wb_rd_q <= rd;
      if (err_set)  err_q   <= 1'b1;
    end
  end

  assign bus.o_stall    = ((state == IDLE) && (bus.i_mem_data_access != 4'd0)) ||
                          (state == ACCESS) || (state == WAITRDY);
  assign bus.o_dmem_req = (state == ACCESS) || (state == WAITRDY);
  assign bus.o_dmem_we  = bus.o_dmem_req && (op == OP_STR);
  assign bus.o_rf_we_r  = rf_we_q;
  assign bus.o_wb_rd_r  = wb_rd_q;
  assign bus.o_err_r    = err_q;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_ctrl_mem_stall.sv
// Bench for ctrl_mem_stall: per-transaction reference model producing a per-cycle
// expected queue, one negedge compare process, and literal pins on directed cases.
module tb_ctrl_mem_stall;
  localparam int         TIMEOUT = 15;
  localparam logic [4:0] OP_STR  = 5'b01100;
  localparam logic [4:0] OP_LDR  = 5'b01101;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ctrl_mem_stall_if bus();

  ctrl_mem_stall #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected per-cycle outputs: {stall, req, we, rf_we, wb_rd[2:0], err}.
  logic [7:0] exp_q[$];
  logic       exp_err = 1'b0;
  logic [2:0] exp_wb  = 3'd0;

  int mon_stall = 0;
  int mon_req   = 0;
  int mon_we    = 0;
  int mon_rfwe  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: one expected entry per driven cycle.
  always @(negedge clk) begin
    logic [7:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("stall",    32'(bus.o_stall),    32'(e[7]));
      chk("dmem_req", 32'(bus.o_dmem_req), 32'(e[6]));
      chk("dmem_we",  32'(bus.o_dmem_we),  32'(e[5]));
      chk("rf_we",    32'(bus.o_rf_we_r),  32'(e[4]));
      chk("wb_rd",    32'(bus.o_wb_rd_r),  32'(e[3:1]));
      chk("err",      32'(bus.o_err_r),    32'(e[0]));
    end
  end

  always @(negedge clk) begin
    if (bus.o_stall)    mon_stall++;
    if (bus.o_dmem_req) mon_req++;
    if (bus.o_dmem_we)  mon_we++;
    if (bus.o_rf_we_r)  mon_rfwe++;
  end

  task automatic clr_mon();
    mon_stall = 0;
    mon_req   = 0;
    mon_we    = 0;
    mon_rfwe  = 0;
  endtask

  task automatic drive(input logic r, input logic [15:0] ir, input logic [3:0] acc, input logic rdy);
    @(posedge clk);
    #1;
    rst                   = r;
    bus.i_ir_ex           = ir;
    bus.i_mem_data_access = acc;
    bus.i_dmem_ready      = rdy;
  endtask

  task automatic push_exp(input logic st, input logic rq, input logic we, input logic rfw);
    exp_q.push_back({st, rq, we, rfw, exp_wb, exp_err});
  endtask

  task automatic idle(input int gap);
    for (int i = 0; i < gap; i++) begin
      drive(1'b0, 16'($urandom), 4'd0, 1'($urandom));
      push_exp(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One access, relative cycle t: t=0 detect in IDLE, t=1..n access cycles,
  // completion at the first t in [n, n+TIMEOUT] with ready (else timeout at n+TIMEOUT),
  // then a single done cycle. abort_at >= 1 asserts rst in that cycle.
  task automatic run_txn(input logic [15:0] ir, input logic [3:0] n, input logic [31:0] rdy,
                         input int abort_at, input int gap);
    int         c;
    logic       tmo;
    logic [4:0] op;
    logic       st, rq, rfw;
    op = ir[15:11];
    c  = -1;
    for (int t = int'(n); t <= int'(n) + TIMEOUT; t++)
      if (c < 0 && rdy[t]) c = t;
    tmo = (c < 0);
    if (tmo) c = int'(n) + TIMEOUT;
    for (int t = 0; t <= c + 1; t++) begin
      drive(t == abort_at, (t == 0) ? ir : 16'($urandom), (t == 0) ? n : 4'($urandom), rdy[t]);
      st  = (t <= c);
      rq  = (t >= 1) && (t <= c);
      rfw = (t == c + 1) && (op == OP_LDR) && !tmo;
      if (rfw) exp_wb = ir[2:0];
      if ((t == c + 1) && tmo) exp_err = 1'b1;
      push_exp(st, rq, rq && (op == OP_STR), rfw);
      if (t == abort_at) begin
        exp_err = 1'b0;
        exp_wb  = 3'd0;
        break;
      end
    end
    idle(gap);
  endtask

  initial begin
    logic [15:0] ir;
    logic [4:0]  op;
    logic [3:0]  n;
    logic [31:0] rdy;
    int          mode, ab;

    bus.i_ir_ex           = 16'h0000;
    bus.i_mem_data_access = 4'd0;
    bus.i_dmem_ready      = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, then ADD in EX with no access.
    clr_mon();
    idle(6);
    idle(1);
    chk("idle_stall_cycles", 32'(mon_stall), 32'd0);
    chk("idle_req_cycles",   32'(mon_req),   32'd0);

    // LDR r3, two cycles, ready throughout.
    clr_mon();
    run_txn(16'h6813, 4'd2, 32'hFFFF_FFFF, -1, 2);
    chk("ldr_stall_cycles", 32'(mon_stall), 32'd3);
    chk("ldr_req_cycles",   32'(mon_req),   32'd2);
    chk("ldr_we_cycles",    32'(mon_we),    32'd0);
    chk("ldr_rfwe_pulses",  32'(mon_rfwe),  32'd1);
    chk("ldr_wb_rd",        32'(bus.o_wb_rd_r), 32'd3);

    // STR with ready low for the first four cycles.
    clr_mon();
    run_txn(16'h6013, 4'd2, 32'hFFFF_FFF0, -1, 2);
    chk("str_stall_cycles", 32'(mon_stall), 32'd5);
    chk("str_we_cycles",    32'(mon_we),    32'd4);
    chk("str_rfwe_pulses",  32'(mon_rfwe),  32'd0);

    // LDR that never gets ready: timeout, then a serviced access.
    clr_mon();
    run_txn(16'h6813, 4'd2, 32'h0000_0000, -1, 2);
    chk("tmo_req_cycles",   32'(mon_req),   32'd17);
    chk("tmo_rfwe_pulses",  32'(mon_rfwe),  32'd0);
    chk("tmo_err",          32'(bus.o_err_r), 32'd1);

    // Back-to-back LDR r3 / LDR r5.
    clr_mon();
    run_txn(16'h6813, 4'd2, 32'hFFFF_FFFF, -1, 0);
    run_txn(16'h6815, 4'd2, 32'hFFFF_FFFF, -1, 2);
    chk("b2b_rfwe_pulses",  32'(mon_rfwe),  32'd2);
    chk("b2b_req_cycles",   32'(mon_req),   32'd4);
    chk("b2b_wb_rd",        32'(bus.o_wb_rd_r), 32'd5);
    chk("err_sticky",       32'(bus.o_err_r), 32'd1);

    // Single-cycle access and a non-memory op with an access request.
    clr_mon();
    run_txn(16'h6817, 4'd1, 32'hFFFF_FFFF, -1, 1);
    chk("acc1_req_cycles",   32'(mon_req),   32'd1);
    chk("acc1_stall_cycles", 32'(mon_stall), 32'd2);
    clr_mon();
    run_txn(16'h7013, 4'd3, 32'hFFFF_FFFF, -1, 1);
    chk("other_rfwe_pulses", 32'(mon_rfwe),  32'd0);

    // Reset while waiting for ready.
    clr_mon();
    run_txn(16'h6813, 4'd2, 32'h0000_0000, 5, 2);
    chk("rst_err_clear",   32'(bus.o_err_r),   32'd0);
    chk("rst_wb_clear",    32'(bus.o_wb_rd_r), 32'd0);
    chk("rst_rfwe_pulses", 32'(mon_rfwe),      32'd0);

    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 2))
        0:       op = OP_LDR;
        1:       op = OP_STR;
        default: op = 5'($urandom);
      endcase
      ir   = {op, 11'($urandom)};
      n    = 4'($urandom_range(1, 15));
      mode = $urandom_range(0, 7);
      if (mode == 0)      rdy = 32'h0;
      else if (mode == 1) rdy = 32'hFFFF_FFFF;
      else                rdy = $urandom() & $urandom();
      ab = ($urandom_range(0, 15) == 0) ? $urandom_range(1, int'(n)) : -1;
      run_txn(ir, n, rdy, ab, $urandom_range(0, 3));
    end

    idle(2);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
